// File: rtl/bf16_pack.sv
// Rounds a normalised bf16 candidate (8-bit significand plus G/R/S) and packs
// it into bfloat16. Stage 1 classifies and rounds; stage 2 resolves range and packs.
module bf16_pack (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        sign_i,
    input  logic [9:0]  exp_i,
    input  logic [10:0] mant_i,
    input  logic        is_nan_i,
    input  logic        is_inf_i,
    input  logic        is_zero_i,
    input  logic        invalid_i,
    input  logic [1:0]  rm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] result_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o,
    output logic        invalid_o
);

    typedef enum logic [1:0] {
        CLS_FIN  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;

    function automatic logic round_inc(input logic [1:0] rm, input logic s,
                                       input logic l, input logic g,
                                       input logic r, input logic st);
        logic inc;
        unique case (rm)
            2'b00:   inc = g & (r | st | l);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~s & (g | r | st);
            default: inc = s & (g | r | st);
        endcase
        return inc;
    endfunction

    // Overflow saturates to Inf only when rounding is allowed to move away from zero.
    function automatic logic [15:0] sat_result(input logic [1:0] rm, input logic s);
        logic to_inf;
        if (rm == RM_RNE)      to_inf = 1'b1;
        else if (rm == RM_RTZ) to_inf = 1'b0;
        else if (rm == RM_RUP) to_inf = ~s;
        else                   to_inf = s;
        return to_inf ? {s, 8'hFF, 7'h00} : {s, 15'h7F7F};
    endfunction

    logic adv_p2;
    logic vld_p1, vld_p2;

    assign adv_p2      = ~vld_p2 | out_ready_i;
    assign in_ready_o  = ~vld_p1 | adv_p2;
    assign out_valid_o = vld_p2;

    // ---- stage 0 -> 1: classify and round ----
    cls_t               cls_s0;
    logic               inc_s0, carry_s0, grs_s0;
    logic [6:0]         frac_s0;
    logic signed [10:0] exp_s0;

    always_comb begin
        cls_s0 = CLS_FIN;
        if (is_nan_i | invalid_i) cls_s0 = CLS_NAN;
        else if (is_inf_i)        cls_s0 = CLS_INF;
        else if (is_zero_i)       cls_s0 = CLS_ZERO;
    end

    assign grs_s0   = |mant_i[2:0];
    assign inc_s0   = round_inc(rm_i, sign_i, mant_i[3], mant_i[2], mant_i[1], mant_i[0]);
    assign carry_s0 = inc_s0 & (&mant_i[10:3]);
    assign frac_s0  = mant_i[9:3] + {6'd0, inc_s0};
    assign exp_s0   = $signed({exp_i[9], exp_i}) + $signed({10'd0, carry_s0});

    cls_t               cls_p1;
    logic               sign_p1, inv_p1, inexact_p1;
    logic [1:0]         rm_p1;
    logic [6:0]         frac_p1;
    logic signed [10:0] exp_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         vld_p1 <= 1'b0;
        else if (in_ready_o) vld_p1 <= in_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) begin
            cls_p1     <= cls_s0;
            sign_p1    <= sign_i;
            inv_p1     <= invalid_i;
            inexact_p1 <= grs_s0;
            rm_p1      <= rm_i;
            frac_p1    <= frac_s0;
            exp_p1     <= exp_s0;
        end
    end

    // ---- stage 1 -> 2: range check and pack ----
    logic        ovf_s1, unf_s1;
    logic [15:0] res_s1;
    logic [3:0]  flags_s1;

    assign ovf_s1 = (exp_p1 >= 11'sd255);
    assign unf_s1 = (exp_p1 <= 11'sd0);

    always_comb begin
        res_s1   = 16'h0000;
        flags_s1 = 4'b0000;
        unique case (cls_p1)
            CLS_NAN: begin
                res_s1   = 16'h7FC0;
                flags_s1 = {3'b000, inv_p1};
            end
            CLS_INF:  res_s1 = {sign_p1, 8'hFF, 7'h00};
            CLS_ZERO: res_s1 = {sign_p1, 15'h0000};
            default: begin
                if (ovf_s1) begin
                    res_s1   = sat_result(rm_p1, sign_p1);
                    flags_s1 = 4'b1010;
                end else if (unf_s1) begin
                    res_s1   = {sign_p1, 15'h0000};
                    flags_s1 = 4'b0110;
                end else begin
                    res_s1   = {sign_p1, exp_p1[7:0], frac_p1};
                    flags_s1 = {2'b00, inexact_p1, 1'b0};
                end
            end
        endcase
    end

    // Output registers are reset too so result/flags read zero while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p2      <= 1'b0;
            result_o    <= 16'h0000;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
            invalid_o   <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_o <= res_s1;
                {overflow_o, underflow_o, inexact_o, invalid_o} <= flags_s1;
            end
        end
    end

endmodule

// File: tb/tb_bf16_pack.sv
// Self-checking bench for bf16_pack: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against a numeric reference model.
module tb_bf16_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        sign_in;
    logic signed [9:0] exp_in;
    logic [10:0] mant_in;
    logic        nan_in, inf_in, zero_in, inv_in;
    logic [1:0]  rm_in;
    logic [15:0] result;
    logic        ovf, unf, inex, inv_out;

    always #5 clk = ~clk;

    bf16_pack dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sign_i(sign_in), .exp_i(exp_in), .mant_i(mant_in),
        .is_nan_i(nan_in), .is_inf_i(inf_in), .is_zero_i(zero_in), .invalid_i(inv_in),
        .rm_i(rm_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result),
        .overflow_o(ovf), .underflow_o(unf), .inexact_o(inex), .invalid_o(inv_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // {result[15:0], overflow, underflow, inexact, invalid}
    function automatic logic [19:0] model(input logic s, input logic signed [9:0] e,
                                          input logic [10:0] m, input logic [1:0] r,
                                          input logic nan, input logic inv,
                                          input logic inf, input logic zero);
        int kept, rem, ex;
        bit up, to_inf;
        logic [7:0] e8;
        logic [6:0] f7;
        if (nan || inv) return {16'h7FC0, 3'b000, inv};
        if (inf)        return {s, 8'hFF, 7'h00, 4'b0000};
        if (zero)       return {s, 15'h0000, 4'b0000};
        kept = int'(m) / 8;
        rem  = int'(m) % 8;
        ex   = int'(e);
        case (r)
            2'b00:   up = (rem > 4) || (rem == 4 && (kept % 2) == 1);
            2'b01:   up = 1'b0;
            2'b10:   up = !s && rem != 0;
            default: up = s && rem != 0;
        endcase
        kept = kept + int'(up);
        if (kept >= 256) begin
            kept = kept / 2;
            ex   = ex + 1;
        end
        if (ex >= 255) begin
            to_inf = (r == 2'b00) || (r == 2'b10 && !s) || (r == 2'b11 && s);
            return {to_inf ? {s, 8'hFF, 7'h00} : {s, 15'h7F7F}, 4'b1010};
        end
        if (ex <= 0) return {s, 15'h0000, 4'b0110};
        e8 = ex[7:0];
        f7 = kept[6:0];
        return {s, e8, f7, 2'b00, rem != 0, 1'b0};
    endfunction

    logic [19:0] exp_q[$];
    bit          ovr_en = 1'b0;
    logic [19:0] ovr_val;

    // Called just after a falling edge; evaluates handshakes for the coming rising edge.
    task automatic tick(output bit acc);
        logic [19:0] e;
        #1;
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(ovr_en ? ovr_val
                                        : model(sign_in, exp_in, mant_in, rm_in,
                                                nan_in, inv_in, inf_in, zero_in));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("result", {16'd0, result}, {16'd0, e[19:4]});
                check("flags", {28'd0, ovf, unf, inex, inv_out}, {28'd0, e[3:0]});
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic s, input logic signed [9:0] e, input logic [10:0] m,
                          input logic [1:0] r, input logic [3:0] cls);
        sign_in = s; exp_in = e; mant_in = m; rm_in = r;
        {nan_in, inv_in, inf_in, zero_in} = cls;
    endtask

    task automatic send(input logic s, input logic signed [9:0] e, input logic [10:0] m,
                        input logic [1:0] r, input logic [3:0] cls, input logic [19:0] expv);
        bit acc = 1'b0;
        set_in(s, e, m, r, cls);
        ovr_en = 1'b1; ovr_val = expv; in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; ovr_en = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(acc);
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic rand_in();
        int mode;
        int r;
        sign_in = 1'($urandom);
        mode = $urandom_range(0, 7);
        if (mode == 0)      exp_in = 10'(250 + int'($urandom_range(0, 6)));
        else if (mode == 1) exp_in = 10'(int'($urandom_range(0, 4)) - 2);
        else                exp_in = 10'($urandom);
        mant_in = 11'($urandom);
        if ($urandom_range(0, 3) == 0) mant_in[10:3] = 8'hFF;
        rm_in = 2'($urandom);
        r = $urandom_range(0, 15);
        nan_in  = (r == 0);
        inv_in  = (r == 1) || (r == 5);
        inf_in  = (r == 2) || (r == 5);
        zero_in = (r == 3) || (r == 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int idx;
        logic [15:0] hold;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(1'b0, 10'sd0, 11'd0, 2'b00, 4'b0000);
        @(negedge clk); #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_flags", {28'd0, ovf, unf, inex, inv_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // 1.0 with latency observation
        send(1'b0, 10'sd127, 11'b100_0000_0000, 2'b00, 4'b0000, {16'h3F80, 4'b0000});
        #1 check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2", {31'd0, out_valid}, 32'd1);
        tick(acc);
        drain();

        send(1'b0, 10'sd127, 11'b111_1111_1100, 2'b00, 4'b0000, {16'h4000, 4'b0010});
        send(1'b0, 10'sd127, 11'b111_1111_1100, 2'b01, 4'b0000, {16'h3FFF, 4'b0010});
        send(1'b0, 10'sd254, 11'b111_1111_1110, 2'b00, 4'b0000, {16'h7F80, 4'b1010});
        send(1'b0, 10'sd254, 11'b111_1111_1110, 2'b01, 4'b0000, {16'h7F7F, 4'b0010});
        send(1'b1, 10'sd254, 11'b111_1111_1110, 2'b10, 4'b0000, {16'hFF7F, 4'b0010});
        send(1'b0, 10'sd255, 11'b100_0000_0000, 2'b01, 4'b0000, {16'h7F7F, 4'b1010});
        send(1'b0, 10'sd300, 11'b100_0000_0000, 2'b11, 4'b0000, {16'h7F7F, 4'b1010});
        send(1'b1, 10'sd300, 11'b100_0000_0000, 2'b11, 4'b0000, {16'hFF80, 4'b1010});
        send(1'b1, 10'sd511, 11'b100_0000_0000, 2'b10, 4'b0000, {16'hFF7F, 4'b1010});
        send(1'b1, 10'sd0,   11'b0, 2'b00, 4'b1000, {16'h7FC0, 4'b0000});
        send(1'b0, 10'sd5,   11'b0, 2'b00, 4'b0100, {16'h7FC0, 4'b0001});
        send(1'b1, 10'sd0,   11'b0, 2'b00, 4'b0010, {16'hFF80, 4'b0000});
        send(1'b0, 10'sd0,   11'b0, 2'b00, 4'b0011, {16'h7F80, 4'b0000});
        send(1'b1, 10'sd0,   11'b0, 2'b00, 4'b0001, {16'h8000, 4'b0000});
        send(1'b0, 10'sd0,   11'b100_0000_0000, 2'b00, 4'b0000, {16'h0000, 4'b0110});
        send(1'b1, -10'sd512, 11'b111_1111_1111, 2'b11, 4'b0000, {16'h8000, 4'b0110});
        drain();

        // Backpressure: three offered inputs, stalled output
        out_ready = 1'b0; idx = 0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b0, 10'(100 + idx), 11'b101_0000_0000, 2'b00, 4'b0000);
            tick(acc);
            if (acc) idx++;
        end
        check("bp_accepts", idx, 32'd2);
        #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        hold = result;
        @(negedge clk);
        set_in(1'b0, 10'(100 + idx), 11'b101_0000_0000, 2'b00, 4'b0000);
        tick(acc);
        check("bp_stable", {16'd0, result}, {16'd0, hold});
        out_ready = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) tick(acc);
        check("bp_third_acc", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        drain();

        // Reset with two items in flight
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(1'b0, 10'sd130, 11'b110_0000_0000, 2'b00, 4'b0000);
        tick(acc);
        set_in(1'b1, 10'sd131, 11'b110_0000_0000, 2'b00, 4'b0000);
        tick(acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", {16'd0, result}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick(acc);
        #1 check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Randomized traffic with random backpressure
        acc = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                rand_in();
                in_valid = ($urandom_range(0, 3) != 0);
            end
            tick(acc);
        end
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
